sobel_window_gen: RTL and testbench

- Upstream neighbour of the Sobel core.
- Accepts a raster-order 8-bit grayscale pixel stream, one pixel per accepted cycle.
- Uses two on-chip line buffers and a 3x3 register array to present the Z1..Z9 neighbourhood, plus valid_data and black_data qualifiers, directly to the core.
- No backpressure: the core is combinational and consumes every window.

---
 rtl/sobel_window_gen_if.sv | 31 +++
 rtl/sobel_window_gen.sv | 155 +++++++++++++++
 tb/tb_sobel_window_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sobel_window_gen_if.sv
// ----------------------------------------------------------------------------
// sobel_window_gen_if
//   Bundle between a raster pixel source and the Sobel window generator.
//   Source side : pixel_in[7:0], pixel_valid, sof (pixel (0,0) marker).
//   Window side : Z1..Z9[7:0] 3x3 neighbourhood (Z1 = top-left, Z9 = newest),
//                 valid_data, black_data, eof, sync_err qualifiers.
//   master : drives the pixel stream and observes the window outputs.
//   slave  : the window generator itself.
// ----------------------------------------------------------------------------
interface sobel_window_gen_if;
    logic [7:0] pixel_in;
    logic       pixel_valid;
    logic       sof;
    logic [7:0] Z1, Z2, Z3, Z4, Z5, Z6, Z7, Z8, Z9;
    logic       valid_data;
    logic       black_data;
    logic       eof;
    logic       sync_err;

    modport master (
        output pixel_in, pixel_valid, sof,
        input  Z1, Z2, Z3, Z4, Z5, Z6, Z7, Z8, Z9,
        input  valid_data, black_data, eof, sync_err
    );

    modport slave (
        input  pixel_in, pixel_valid, sof,
        output Z1, Z2, Z3, Z4, Z5, Z6, Z7, Z8, Z9,
        output valid_data, black_data, eof, sync_err
    );
endinterface

// File: rtl/sobel_window_gen.sv
// ----------------------------------------------------------------------------
// sobel_window_gen
//   Turns a raster-order 8-bit pixel stream into a 3x3 neighbourhood for a
//   combinational Sobel core. Two line buffers hold rows r-1 and r-2; a 3x3
//   shift array presents the window one cycle after each accepted pixel.
//   Ports:
//     clk    : system clock, rising edge
//     rst_n  : asynchronous active-low reset
//     win_if : slave side of sobel_window_gen_if (pixel stream in, window out)
//   Window for the pixel accepted at (r,c): Z1..Z3 = row r-2, Z4..Z6 = row
//   r-1, Z7..Z9 = row r, left to right columns c-2..c. black_data marks any
//   window touching the top two rows or left two columns.
// ----------------------------------------------------------------------------
module sobel_window_gen #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int COL_W      = $clog2(IMG_WIDTH),
    parameter int ROW_W      = $clog2(IMG_HEIGHT)
) (
    input  logic               clk,
    input  logic               rst_n,
    sobel_window_gen_if.slave  win_if
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
    localparam logic [ROW_W-1:0] ROW_ZERO = {ROW_W{1'b0}};

    // Line buffers: lb1 holds row r-1, lb2 holds row r-2, indexed by column.
    logic [7:0] lb1_mem [IMG_WIDTH];
    logic [7:0] lb2_mem [IMG_WIDTH];

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] col_cur_s;
    logic [ROW_W-1:0] row_cur_s;
    logic [COL_W-1:0] col_nxt_s;
    logic [ROW_W-1:0] row_nxt_s;

    logic             accept_s;
    logic             at_origin_s;
    logic             frame_last_s;
    logic             border_s;
    logic             sync_err_nxt_s;
    logic [7:0]       lb1_rd_s;
    logic [7:0]       lb2_rd_s;

    // z_r[0] = Z1 ... z_r[8] = Z9
    logic [8:0][7:0]  z_r;
    logic             valid_data_r;
    logic             black_data_r;
    logic             eof_r;
    logic             sync_err_r;

    // Position of the current pixel, next counter values and window qualifiers.
    always_comb begin
        accept_s       = win_if.pixel_valid;
        at_origin_s    = (col_r == COL_ZERO) && (row_r == ROW_ZERO);
        col_cur_s      = col_r;
        row_cur_s      = row_r;
        col_nxt_s      = col_r;
        row_nxt_s      = row_r;
        frame_last_s   = 1'b0;

        // sof forces (0,0) no matter where the counters are.
        if (win_if.sof) begin
            col_cur_s = COL_ZERO;
            row_cur_s = ROW_ZERO;
        end else begin
            col_cur_s = col_r;
            row_cur_s = row_r;
        end

        if (col_cur_s == COL_LAST) begin
            col_nxt_s = COL_ZERO;
            if (row_cur_s == ROW_LAST) begin
                row_nxt_s    = ROW_ZERO;
                frame_last_s = 1'b1;
            end else begin
                row_nxt_s    = row_cur_s + ROW_W'(1);
                frame_last_s = 1'b0;
            end
        end else begin
            col_nxt_s    = col_cur_s + COL_W'(1);
            row_nxt_s    = row_cur_s;
            frame_last_s = 1'b0;
        end

        border_s       = (row_cur_s < ROW_W'(2)) || (col_cur_s < COL_W'(2));
        sync_err_nxt_s = accept_s && win_if.sof && !at_origin_s;

        // Asynchronous read gives the old word even when the same column is
        // written on this edge.
        lb1_rd_s = lb1_mem[col_cur_s];
        lb2_rd_s = lb2_mem[col_cur_s];
    end

    // Line-buffer writes; contents survive reset, stale data is masked by black_data.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb2_mem[col_cur_s] <= lb1_rd_s;
            lb1_mem[col_cur_s] <= win_if.pixel_in;
        end
    end

    // Counters, window shift array and output qualifiers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_r        <= COL_ZERO;
            row_r        <= ROW_ZERO;
            z_r          <= {9{8'h00}};
            valid_data_r <= 1'b0;
            black_data_r <= 1'b0;
            eof_r        <= 1'b0;
            sync_err_r   <= 1'b0;
        end else if (accept_s) begin
            col_r        <= col_nxt_s;
            row_r        <= row_nxt_s;
            z_r[0]       <= z_r[1];
            z_r[1]       <= z_r[2];
            z_r[2]       <= lb2_rd_s;
            z_r[3]       <= z_r[4];
            z_r[4]       <= z_r[5];
            z_r[5]       <= lb1_rd_s;
            z_r[6]       <= z_r[7];
            z_r[7]       <= z_r[8];
            z_r[8]       <= win_if.pixel_in;
            valid_data_r <= 1'b1;
            black_data_r <= border_s;
            eof_r        <= frame_last_s;
            sync_err_r   <= sync_err_nxt_s;
        end else begin
            // Idle: window and its qualifiers (incl. eof) stay with the held
            // window; only the per-edge pulses drop.
            valid_data_r <= 1'b0;
            sync_err_r   <= 1'b0;
        end
    end

    assign win_if.Z1         = z_r[0];
    assign win_if.Z2         = z_r[1];
    assign win_if.Z3         = z_r[2];
    assign win_if.Z4         = z_r[3];
    assign win_if.Z5         = z_r[4];
    assign win_if.Z6         = z_r[5];
    assign win_if.Z7         = z_r[6];
    assign win_if.Z8         = z_r[7];
    assign win_if.Z9         = z_r[8];
    assign win_if.valid_data = valid_data_r;
    assign win_if.black_data = black_data_r;
    assign win_if.eof        = eof_r;
    assign win_if.sync_err   = sync_err_r;

endmodule

// File: tb/tb_sobel_window_gen.sv
// ----------------------------------------------------------------------------
// tb_sobel_window_gen
//   Directed bench for sobel_window_gen on an 8x6 image. The bench keeps the
//   image being streamed in img[][] and derives every expected window from it.
// ----------------------------------------------------------------------------
module tb_sobel_window_gen;

    localparam int W = 8;
    localparam int H = 6;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    logic [7:0] img [0:H-1][0:W-1];

    sobel_window_gen_if bus ();

    sobel_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .win_if (bus)
    );

    logic [71:0] got_win;
    assign got_win = {bus.Z1, bus.Z2, bus.Z3, bus.Z4, bus.Z5, bus.Z6, bus.Z7, bus.Z8, bus.Z9};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected window for pixel (r,c), only meaningful for r>=2, c>=2.
    function automatic logic [71:0] exp_win(input int r, input int c);
        return {img[r-2][c-2], img[r-2][c-1], img[r-2][c],
                img[r-1][c-2], img[r-1][c-1], img[r-1][c],
                img[r][c-2],   img[r][c-1],   img[r][c]};
    endfunction

    task automatic fill_ramp(input logic [7:0] base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = base + 8'(r * 16 + c);
    endtask

    task automatic push(input logic [7:0] p, input logic s);
        bus.pixel_in    = p;
        bus.pixel_valid = 1'b1;
        bus.sof         = s;
        @(posedge clk);
        #1;
        bus.pixel_valid = 1'b0;
        bus.sof         = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        tests_run++;
        if ({got_win, bus.valid_data, bus.black_data, bus.eof, bus.sync_err} !== 76'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got win=%h v=%b b=%b e=%b s=%b, want all 0",
                     got_win, bus.valid_data, bus.black_data, bus.eof, bus.sync_err);
        end
    endtask

    task automatic test_back_to_back();
        int n_valid;
        int n_black;
        int exp_black_cnt;
        logic eb;
        n_valid = 0; n_black = 0; exp_black_cnt = 0;
        fill_ramp(8'h00);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                push(img[r][c], (r == 0 && c == 0));
                eb = (r < 2) || (c < 2);
                if (eb) exp_black_cnt++;
                if (bus.valid_data === 1'b1) n_valid++;
                if (bus.black_data === 1'b1) n_black++;
                tests_run++;
                if (bus.black_data !== eb) begin
                    tests_failed++;
                    $display("FAIL b2b_black(%0d,%0d): got %b want %b", r, c, bus.black_data, eb);
                end
                tests_run++;
                if (bus.eof !== (r == H-1 && c == W-1)) begin
                    tests_failed++;
                    $display("FAIL b2b_eof(%0d,%0d): got %b want %b", r, c, bus.eof, (r == H-1 && c == W-1));
                end
                if (!eb) begin
                    tests_run++;
                    if (got_win !== exp_win(r, c)) begin
                        tests_failed++;
                        $display("FAIL b2b_win(%0d,%0d): got %h want %h", r, c, got_win, exp_win(r, c));
                    end
                end
                if (r == 2 && c == 2) begin
                    tests_run++;
                    if ({bus.Z1, bus.Z5, bus.Z9} !== 24'h00_11_22) begin
                        tests_failed++;
                        $display("FAIL b2b_z22: got Z1/Z5/Z9=%h want 001122", {bus.Z1, bus.Z5, bus.Z9});
                    end
                end
            end
        end
        tests_run++;
        if (n_valid !== W * H) begin
            tests_failed++;
            $display("FAIL b2b_valid_count: got %0d want %0d", n_valid, W * H);
        end
        tests_run++;
        if (n_black !== exp_black_cnt) begin
            tests_failed++;
            $display("FAIL b2b_black_count: got %0d want %0d", n_black, exp_black_cnt);
        end
        idle(1);
        tests_run++;
        if (bus.valid_data !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_valid_drop: got %b want 0", bus.valid_data);
        end
    endtask

    task automatic test_gaps();
        logic eb;
        fill_ramp(8'h00);
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                push(img[r][c], (r == 0 && c == 0));
                eb = (r < 2) || (c < 2);
                tests_run++;
                if ({bus.valid_data, bus.black_data} !== {1'b1, eb}) begin
                    tests_failed++;
                    $display("FAIL gap_accept(%0d,%0d): got v/b=%b%b want 1%b", r, c, bus.valid_data, bus.black_data, eb);
                end
                if (!eb) begin
                    tests_run++;
                    if (got_win !== exp_win(r, c)) begin
                        tests_failed++;
                        $display("FAIL gap_win(%0d,%0d): got %h want %h", r, c, got_win, exp_win(r, c));
                    end
                end
                idle(1);
                tests_run++;
                if ({bus.valid_data, bus.black_data} !== {1'b0, eb}) begin
                    tests_failed++;
                    $display("FAIL gap_idle(%0d,%0d): got v/b=%b%b want 0%b", r, c, bus.valid_data, bus.black_data, eb);
                end
                if (!eb) begin
                    tests_run++;
                    if (got_win !== exp_win(r, c)) begin
                        tests_failed++;
                        $display("FAIL gap_hold(%0d,%0d): got %h want %h", r, c, got_win, exp_win(r, c));
                    end
                end
            end
        end
    endtask

    task automatic test_two_frames();
        logic eb;
        fill_ramp(8'h00);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                push(img[r][c], (r == 0 && c == 0));
        tests_run++;
        if (bus.eof !== 1'b1) begin
            tests_failed++;
            $display("FAIL two_frames_eof1: got %b want 1", bus.eof);
        end
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                push(8'hFF, (r == 0 && c == 0));
                eb = (r < 2) || (c < 2);
                if (r == 0 && c == 0) begin
                    tests_run++;
                    if (bus.sync_err !== 1'b0) begin
                        tests_failed++;
                        $display("FAIL two_frames_sof_wrap: sync_err got %b want 0", bus.sync_err);
                    end
                end
                tests_run++;
                if (bus.black_data !== eb) begin
                    tests_failed++;
                    $display("FAIL two_frames_black(%0d,%0d): got %b want %b", r, c, bus.black_data, eb);
                end
                if (!eb) begin
                    tests_run++;
                    if (got_win !== {9{8'hFF}}) begin
                        tests_failed++;
                        $display("FAIL two_frames_win(%0d,%0d): got %h want all FF", r, c, got_win);
                    end
                end
            end
        end
    endtask

    task automatic test_sof_resync();
        int  n_eof;
        logic eb;
        n_eof = 0;
        fill_ramp(8'h00);
        // Stream (0,0)..(3,3), then inject sof where (3,4) would be.
        for (int i = 0; i < 3 * W + 4; i++)
            push(img[i / W][i % W], (i == 0));
        push(img[0][0], 1'b1);
        tests_run++;
        if ({bus.sync_err, bus.black_data} !== 2'b11) begin
            tests_failed++;
            $display("FAIL resync_pulse: got sync_err/black=%b%b want 11", bus.sync_err, bus.black_data);
        end
        for (int i = 1; i < W * H; i++) begin
            push(img[i / W][i % W], 1'b0);
            eb = ((i / W) < 2) || ((i % W) < 2);
            if (bus.eof === 1'b1) n_eof++;
            if (i == 1) begin
                tests_run++;
                if (bus.sync_err !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL resync_one_cycle: sync_err got %b want 0", bus.sync_err);
                end
            end
            if (!eb) begin
                tests_run++;
                if (got_win !== exp_win(i / W, i % W)) begin
                    tests_failed++;
                    $display("FAIL resync_win(%0d,%0d): got %h want %h", i / W, i % W, got_win, exp_win(i / W, i % W));
                end
            end
        end
        tests_run++;
        if ({n_eof, bus.eof} !== {32'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL resync_eof: got %0d pulses, last=%b want 1 pulse on last", n_eof, bus.eof);
        end
    endtask

    task automatic test_reset_midline();
        logic eb;
        fill_ramp(8'h00);
        for (int i = 0; i < 4 * W + 3; i++)
            push(img[i / W][i % W], (i == 0));
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({got_win, bus.valid_data, bus.black_data, bus.eof, bus.sync_err} !== 76'd0) begin
            tests_failed++;
            $display("FAIL rst_async: got win=%h v=%b b=%b, want all 0", got_win, bus.valid_data, bus.black_data);
        end
        idle(2);
        rst_n = 1'b1;
        fill_ramp(8'h80);
        for (int i = 0; i < W * H; i++) begin
            push(img[i / W][i % W], 1'b0);
            eb = ((i / W) < 2) || ((i % W) < 2);
            if (i == 0) begin
                tests_run++;
                if (bus.black_data !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rst_first_black: got %b want 1", bus.black_data);
                end
            end
            if (!eb) begin
                tests_run++;
                if (got_win !== exp_win(i / W, i % W)) begin
                    tests_failed++;
                    $display("FAIL rst_win(%0d,%0d): got %h want %h", i / W, i % W, got_win, exp_win(i / W, i % W));
                end
            end
        end
        tests_run++;
        if (bus.eof !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_eof: got %b want 1", bus.eof);
        end
    endtask

    task automatic test_step_edge();
        int gx;
        int gy;
        int mag;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = (c < 4) ? 8'd0 : 8'd200;
        for (int i = 0; i < W * H; i++) begin
            push(img[i / W][i % W], (i == 0));
            if (i == 2 * W + 4) begin
                tests_run++;
                if ({bus.Z1, bus.Z4, bus.Z7, bus.Z3, bus.Z6, bus.Z9, bus.black_data} !==
                    {8'd0, 8'd0, 8'd0, 8'd200, 8'd200, 8'd200, 1'b0}) begin
                    tests_failed++;
                    $display("FAIL step_win: got Z1/4/7=%0d/%0d/%0d Z3/6/9=%0d/%0d/%0d b=%b want 0s,200s,0",
                             bus.Z1, bus.Z4, bus.Z7, bus.Z3, bus.Z6, bus.Z9, bus.black_data);
                end
                gx = (int'(bus.Z3) + 2 * int'(bus.Z6) + int'(bus.Z9)) - (int'(bus.Z1) + 2 * int'(bus.Z4) + int'(bus.Z7));
                gy = (int'(bus.Z7) + 2 * int'(bus.Z8) + int'(bus.Z9)) - (int'(bus.Z1) + 2 * int'(bus.Z2) + int'(bus.Z3));
                mag = ((gx < 0) ? -gx : gx) + ((gy < 0) ? -gy : gy);
                if (mag > 255) mag = 255;
                tests_run++;
                if (mag !== 255) begin
                    tests_failed++;
                    $display("FAIL step_core: got %0d want 255", mag);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tests_run       = 0;
        tests_failed    = 0;
        rst_n           = 1'b0;
        bus.pixel_in    = 8'h00;
        bus.pixel_valid = 1'b0;
        bus.sof         = 1'b0;
        idle(3);
        test_reset();
        rst_n = 1'b1;
        idle(1);
        test_reset();
        test_back_to_back();
        test_gaps();
        test_two_frames();
        test_sof_resync();
        test_reset_midline();
        test_step_edge();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
